// File: rtl/start_pulse_gen.sv
// rtl/start_pulse_gen.sv - synchronized, debounced, one-shot START pulse generator
//
// Turns a raw pushbutton level into a single-cycle START pulse for the
// downstream 3-bit counter, with a hold-off so a held or bouncing button
// cannot retrigger while the counter runs.
//
// Optional feature: define START_PULSE_COUNT_EN to enable the fire_count
// accepted-pulse counter; otherwise fire_count is tied to 8'h00.
//
// Ports:
//   clock        in   rising-edge clock
//   reset        in   asynchronous active-high reset
//   btn_in       in   raw asynchronous button level (1 = pressed)
//   busy         in   downstream counter mid-sequence (1 = running)
//   start_pulse  out  registered one-cycle START pulse
//   armed        out  registered, 1 while IDLE and ready for a press
//   missed       out  sticky: a debounced press arrived while busy
//   State        out  current FSM state (00 IDLE, 01 DEBOUNCE, 10 FIRE, 11 HOLD)
//   fire_count   out  accepted-pulse count (optional feature)

module start_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLDOFF_CYCLES  = 7
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_in,
  input  logic       busy,
  output logic       start_pulse,
  output logic       armed,
  output logic       missed,
  output logic [1:0] State,
  output logic [7:0] fire_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    DEBOUNCE = 2'b01,
    FIRE     = 2'b10,
    HOLD     = 2'b11
  } state_e;

  localparam logic [3:0] DB_MAX = 4'(DEBOUNCE_CYCLES);
  localparam logic [3:0] HO_MAX = 4'(HOLDOFF_CYCLES);

  logic   s1_q, s1_d;
  logic   btn_sync_q, btn_sync_d;
  state_e state_q, state_d;
  logic [3:0] db_cnt_q, db_cnt_d;
  logic [3:0] hold_cnt_q, hold_cnt_d;
  logic [3:0] rel_cnt_q, rel_cnt_d;
  logic   missed_q, missed_d;
  logic   start_pulse_q, start_pulse_d;
  logic   armed_q, armed_d;

  // Two-flop synchronizer; btn_in is only ever observed through btn_sync_q.
  always_comb begin
    s1_d       = btn_in;
    btn_sync_d = s1_q;
  end

  always_comb begin
    state_d    = state_q;
    db_cnt_d   = db_cnt_q;
    hold_cnt_d = hold_cnt_q;
    rel_cnt_d  = rel_cnt_q;
    missed_d   = missed_q;

    case (state_q)
      IDLE: begin
        if (btn_sync_q) begin
          state_d  = DEBOUNCE;
          db_cnt_d = 4'd1;
        end
      end

      DEBOUNCE: begin
        if (!btn_sync_q) begin
          state_d  = IDLE;
          db_cnt_d = 4'd0;
        end else if (db_cnt_q < DB_MAX) begin
          db_cnt_d = db_cnt_q + 4'd1;
        end else if (busy) begin
          // Counter already running: record the miss, skip the pulse, but
          // still go through hold-off so the same press cannot fire later.
          state_d    = HOLD;
          missed_d   = 1'b1;
          db_cnt_d   = 4'd0;
          hold_cnt_d = HO_MAX;
          rel_cnt_d  = 4'd0;
        end else begin
          state_d  = FIRE;
          db_cnt_d = 4'd0;
        end
      end

      FIRE: begin
        missed_d   = 1'b0;
        state_d    = HOLD;
        hold_cnt_d = HO_MAX;
        rel_cnt_d  = 4'd0;
      end

      HOLD: begin
        // Re-arm needs both a debounced release and an expired hold-off.
        if (rel_cnt_q == DB_MAX && hold_cnt_q == 4'd0) begin
          state_d = IDLE;
        end
        hold_cnt_d = (hold_cnt_q == 4'd0) ? 4'd0 : hold_cnt_q - 4'd1;
        if (btn_sync_q) begin
          rel_cnt_d = 4'd0;
        end else if (rel_cnt_q != DB_MAX) begin
          rel_cnt_d = rel_cnt_q + 4'd1;
        end
      end

      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they are registered yet
    // aligned with State.
    start_pulse_d = (state_d == FIRE);
    armed_d       = (state_d == IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q          <= 1'b0;
      btn_sync_q    <= 1'b0;
      state_q       <= IDLE;
      db_cnt_q      <= 4'd0;
      hold_cnt_q    <= 4'd0;
      rel_cnt_q     <= 4'd0;
      missed_q      <= 1'b0;
      start_pulse_q <= 1'b0;
      armed_q       <= 1'b1;
    end else begin
      s1_q          <= s1_d;
      btn_sync_q    <= btn_sync_d;
      state_q       <= state_d;
      db_cnt_q      <= db_cnt_d;
      hold_cnt_q    <= hold_cnt_d;
      rel_cnt_q     <= rel_cnt_d;
      missed_q      <= missed_d;
      start_pulse_q <= start_pulse_d;
      armed_q       <= armed_d;
    end
  end

`ifdef START_PULSE_COUNT_EN
  logic [7:0] fire_cnt_q, fire_cnt_d;

  // Counts each cycle the pulse is high; wraps naturally at 8 bits.
  always_comb begin
    fire_cnt_d = fire_cnt_q + {7'd0, start_pulse_q};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fire_cnt_q <= 8'd0;
    end else begin
      fire_cnt_q <= fire_cnt_d;
    end
  end

  assign fire_count = fire_cnt_q;
`else
  assign fire_count = 8'h00;
`endif

  assign start_pulse = start_pulse_q;
  assign armed       = armed_q;
  assign missed      = missed_q;
  assign State       = state_q;

endmodule

// File: tb/tb_start_pulse_gen.sv
// tb/tb_start_pulse_gen.sv - scoreboard testbench for start_pulse_gen
module tb_start_pulse_gen;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       btn_in = 1'b0;
  logic       busy = 1'b0;
  logic       start_pulse;
  logic       armed;
  logic       missed;
  logic [1:0] State;
  logic [7:0] fire_count;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_cnt = 0;
  int n_fires  = 0;
  int exp_q[$];

  start_pulse_gen dut (
    .clock      (clock),
    .reset      (reset),
    .btn_in     (btn_in),
    .busy       (busy),
    .start_pulse(start_pulse),
    .armed      (armed),
    .missed     (missed),
    .State      (State),
    .fire_count (fire_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) edge_cnt++;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Scoreboard monitor: every observed pulse must match the next expected edge.
  always @(negedge clock) begin
    if (!reset && start_pulse) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse_edge", edge_cnt, -1);
      end else begin
        check("pulse_edge", edge_cnt, exp_q.pop_front());
      end
    end
  end

  task automatic expect_pulse(input int at_edge);
    exp_q.push_back(at_edge);
    n_fires++;
  endtask

  task automatic at(input int n);
    while (edge_cnt < n) @(negedge clock);
  endtask

  // Short press: released once the debounce has been satisfied; returns in IDLE.
  task automatic press_release(input bit exp_fire);
    int e;
    @(negedge clock);
    e = edge_cnt;
    btn_in = 1'b1;
    if (exp_fire) expect_pulse(e + 7);
    at(e + 5);
    btn_in = 1'b0;
    at(e + 17);
  endtask

  initial begin
    int e;
    int r;

    // Reset state
    repeat (2) @(negedge clock);
    check("rst_state", State, 0);
    check("rst_pulse", start_pulse, 0);
    check("rst_armed", armed, 1);
    check("rst_missed", missed, 0);
    check("rst_fire_count", fire_count, 0);
    reset = 1'b0;

    // Clean press, held 30 cycles
    @(negedge clock);
    e = edge_cnt;
    btn_in = 1'b1;
    expect_pulse(e + 7);
    at(e + 2);
    check("t1_still_idle", State, 0);
    at(e + 3);
    check("t1_debounce", State, 1);
    check("t1_armed_low", armed, 0);
    at(e + 7);
    check("t1_fire", State, 2);
    at(e + 8);
    check("t1_hold", State, 3);
    check("t1_pulse_off", start_pulse, 0);
    at(e + 30);
    r = edge_cnt;
    btn_in = 1'b0;
    at(r + 6);
    check("t1_hold_before_rearm", State, 3);
    at(r + 7);
    check("t1_rearm", State, 0);
    check("t1_armed", armed, 1);

    // Glitches of 1..3 cycles are rejected
    for (int len = 1; len <= 3; len++) begin
      @(negedge clock);
      btn_in = 1'b1;
      repeat (len) @(negedge clock);
      btn_in = 1'b0;
      repeat (8) @(negedge clock);
      check("t2_glitch_idle", State, 0);
    end

    // Retrigger lockout: release 2 cycles then press again while in HOLD
    @(negedge clock);
    e = edge_cnt;
    btn_in = 1'b1;
    expect_pulse(e + 7);
    at(e + 10);
    btn_in = 1'b0;
    at(e + 12);
    btn_in = 1'b1;
    at(e + 32);
    check("t3_locked_hold", State, 3);
    r = edge_cnt;
    btn_in = 1'b0;
    at(r + 6);
    check("t3_hold_before_rearm", State, 3);
    at(r + 7);
    check("t3_rearm", State, 0);

    // Hold-off gating: quick release, re-arm waits for hold_cnt to expire
    @(negedge clock);
    e = edge_cnt;
    btn_in = 1'b1;
    expect_pulse(e + 7);
    at(e + 5);
    btn_in = 1'b0;
    at(e + 15);
    check("t3b_holdoff_active", State, 3);
    at(e + 16);
    check("t3b_holdoff_done", State, 0);

    // Busy collision
    busy = 1'b1;
    @(negedge clock);
    e = edge_cnt;
    btn_in = 1'b1;
    at(e + 7);
    check("t4_missed_hold", State, 3);
    check("t4_missed_flag", missed, 1);
    at(e + 10);
    btn_in = 1'b0;
    at(e + 25);
    check("t4_rearm", State, 0);
    busy = 1'b0;
    check("t4_missed_sticky", missed, 1);
    @(negedge clock);
    e = edge_cnt;
    btn_in = 1'b1;
    expect_pulse(e + 7);
    at(e + 8);
    check("t4_missed_cleared", missed, 0);
    at(e + 10);
    btn_in = 1'b0;
    at(e + 25);

    // busy rises in the very cycle debounce completes
    @(negedge clock);
    e = edge_cnt;
    btn_in = 1'b1;
    at(e + 6);
    busy = 1'b1;
    at(e + 7);
    check("t4b_same_cycle_hold", State, 3);
    check("t4b_same_cycle_missed", missed, 1);
    btn_in = 1'b0;
    busy = 1'b0;
    at(e + 25);
    check("t4b_rearm", State, 0);
    press_release(1'b1);
    check("t4b_missed_cleared", missed, 0);

    // Async reset in the middle of FIRE
    @(negedge clock);
    e = edge_cnt;
    btn_in = 1'b1;
    at(e + 6);
    @(posedge clock);
    #2;
    check("t5_in_fire", State, 2);
    check("t5_pulse_high", start_pulse, 1);
    reset = 1'b1;
    btn_in = 1'b0;
    #1;
    check("t5_async_state", State, 0);
    check("t5_async_pulse", start_pulse, 0);
    check("t5_async_armed", armed, 1);
    @(negedge clock);
    reset = 1'b0;
    repeat (15) @(negedge clock);
    check("t5_idle_after_reset", State, 0);
    press_release(1'b1);

`ifdef START_PULSE_COUNT_EN
    check("t6_fire_count", fire_count, n_fires % 256);
    while (n_fires < 255) press_release(1'b1);
    check("t6_fire_count_255", fire_count, 255);
    press_release(1'b1);
    check("t6_fire_count_wrap", fire_count, 0);
`else
    check("t6_fire_count_tied", fire_count, 0);
`endif

    repeat (4) @(negedge clock);
    check("missing_pulses", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/start_pulse_gen.md
Name: start_pulse_gen

Overview:
- Upstream stage of the 3-bit start-triggered counter (000..110).
- Takes a raw, asynchronous pushbutton/switch level and produces the clean single-cycle START pulse the counter consumes.
- Synchronizes, debounces and one-shots the input, then enforces a hold-off so a held or bouncing button cannot retrigger while the counter runs.
- Honours a busy level fed back from the counter.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronized samples required to accept a press or a release; legal range 1..15.
- HOLDOFF_CYCLES, 7: minimum cycles after a fire (or miss) before re-arming; equals one full 000..110 counter run; legal range 0..15.

Ports:
- clock  input  1  single rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- btn_in  input  1  raw asynchronous button level; 1 = pressed.
- busy  input  1  counter-running level from the downstream counter; 1 = counter mid-sequence.
- start_pulse  output  1  one-cycle START pulse to the counter.
- armed  output  1  1 when in IDLE, ready to accept a press.
- missed  output  1  sticky flag: a debounced press arrived while busy=1.
- State  output  2  current FSM state encoding, for observation.
- fire_count  output  8  accepted-pulse count (optional feature only).

Behaviour:
Reset:
- reset=1 forces immediately, without a clock edge: all registers to 0, State=IDLE(00), start_pulse=0, armed=1, missed=0, fire_count=0.
- Reset mid-operation (any state, including FIRE) aborts with no pulse; a pulse in flight is cut off.

Synchronizer:
- Two flops: btn_in -> s1 -> btn_sync; both reset to 0.
- btn_in is never used unsynchronized.

FSM states (State encoding):
- IDLE (00):
  - armed=1.
  - btn_sync=1 -> DEBOUNCE with db_cnt<=1.
- DEBOUNCE (01):
  - btn_sync=0 -> IDLE, db_cnt<=0 (bounce rejected).
  - btn_sync=1 and db_cnt<DEBOUNCE_CYCLES -> db_cnt<=db_cnt+1.
  - btn_sync=1 and db_cnt==DEBOUNCE_CYCLES and busy=0 -> FIRE.
  - btn_sync=1 and db_cnt==DEBOUNCE_CYCLES and busy=1 -> HOLD, missed<=1, no pulse.
- FIRE (10):
  - start_pulse=1 for exactly this one cycle.
  - missed<=0.
  - Unconditionally -> HOLD next edge.
- HOLD (11):
  - On entry: hold_cnt<=HOLDOFF_CYCLES, rel_cnt<=0.
  - Each cycle: hold_cnt decrements, saturating at 0.
  - btn_sync=0 -> rel_cnt increments, saturating at DEBOUNCE_CYCLES.
  - btn_sync=1 -> rel_cnt<=0.
  - rel_cnt==DEBOUNCE_CYCLES and hold_cnt==0 -> IDLE.

Outputs:
- start_pulse and armed are registered, decoded from state; no combinational path from any input to any output.

Latency:
- btn_in rising before edge n, stable high -> start_pulse high from edge n+(2+DEBOUNCE_CYCLES) to the following edge.
- With defaults: asserted n+6, deasserted n+7.

Boundary conditions:
- Held button: exactly one pulse per press, regardless of hold length.
- Glitch shorter than DEBOUNCE_CYCLES synchronized cycles: no pulse, return to IDLE.
- Press during HOLD: ignored, and resets rel_cnt.
- busy rising in the same cycle the debounce completes: counts as busy, so missed path taken.
- HOLDOFF_CYCLES=0: re-arm gated by release debounce only.
- Counters are 4 bits wide.

Optional Feature:
- Macro: START_PULSE_COUNT_EN.
- Defined: fire_count increments on each cycle start_pulse=1; wraps 255->0; reset clears to 0.
- Undefined: counter logic absent; fire_count tied to 8'h00.
- All other behaviour identical either way.

Test Plan:
- Reset then clean press: reset=1 for 2 cycles; btn_in=1 before edge 10, held 30 cycles -> start_pulse=1 only in the cycle after edge 16; State 00->01->10->11; armed=0 from edge 12.
- Bounce rejection: btn_in pulses 1 for 2 cycles, then 0, repeated 3 times -> start_pulse never 1; State returns to 00 each time.
- Retrigger lockout: press 10 cycles, release 2 cycles, press again -> only one pulse; second press accepted only after release stable 4 cycles and hold-off 7 elapsed (State=00 seen first).
- Busy collision: busy=1 held while a clean press debounces -> no pulse, missed=1; next clean press with busy=0 -> one pulse, missed returns to 0.
- Async reset mid-FIRE: assert reset between edges while State=10 -> start_pulse=0 and State=00 before the next edge; no pulse after reset release until a new press.
- With START_PULSE_COUNT_EN: 3 accepted presses -> fire_count=3; preload 255 presses then 1 more -> fire_count=0.
